// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-RAM write port of the program loader, plus CPU control.
// The master drives the stream and start; the slave (the loader) drives everything else.
interface program_loader_if #(
  parameter int INST_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  logic                  start;
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  ram_inst_write;
  logic [ADDR_WIDTH-1:0] inst_addr;
  logic [INST_WIDTH-1:0] ram_inst_in;
  logic                  cpu_reset;
  logic                  load_done;
  logic                  load_error;

  modport master (
    output start, in_data, in_valid,
    input  in_ready, ram_inst_write, inst_addr, ram_inst_in, cpu_reset, load_done, load_error
  );

  modport slave (
    input  start, in_data, in_valid,
    output in_ready, ram_inst_write, inst_addr, ram_inst_in, cpu_reset, load_done, load_error
  );
endinterface

// File: rtl/program_loader.sv
// Packs stream bytes MSB-first into instructions, writes RAM words 0..NUM_WORDS-1, holds the CPU in reset until loaded.
// RAM strobe one cycle after a word's last byte; in_ready low outside LOAD/CHECK (BEATS+1 cycles/word). CHECKSUM_EN adds a trailer check.
module program_loader #(
  parameter int INST_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_WORDS  = 256
) (
  input logic             clk,
  input logic             rst,
  program_loader_if.slave bus
);
  localparam int BEATS  = INST_WIDTH / 8;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

`ifdef CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, CHECK, DONE, ERROR} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE} state_t;
`endif

  state_t                state, nxt_state;
  logic [ADDR_WIDTH-1:0] addr, nxt_addr;
  logic [BEAT_W-1:0]     beat, nxt_beat;
  logic [INST_WIDTH-1:0] word, nxt_word;
  logic                  in_ready_q, nxt_in_ready;
  logic                  write_q, nxt_write;
  logic [ADDR_WIDTH-1:0] inst_addr_q, nxt_inst_addr;
  logic [INST_WIDTH-1:0] inst_data_q, nxt_inst_data;
  logic                  cpu_reset_q, nxt_cpu_reset;
  logic                  done_q, nxt_done;
  logic                  restart;
  logic                  xfer;
`ifdef CHECKSUM_EN
  logic [7:0]            sum, nxt_sum;
  logic                  error_q, nxt_error;
`endif

  // in_ready_q mirrors "state is LOAD or CHECK", so this is the real handshake
  assign xfer = bus.in_valid && in_ready_q;

  always_comb begin
    nxt_state     = state;
    nxt_addr      = addr;
    nxt_beat      = beat;
    nxt_word      = word;
    nxt_inst_addr = inst_addr_q;
    nxt_inst_data = inst_data_q;
    restart       = 1'b0;
`ifdef CHECKSUM_EN
    nxt_sum       = sum;
`endif

    case (state)
      IDLE: begin
        if (bus.start) begin
          nxt_state = LOAD;
          restart   = 1'b1;
        end
      end
      LOAD: begin
        if (xfer) begin
          nxt_word = INST_WIDTH'({word, bus.in_data});
`ifdef CHECKSUM_EN
          nxt_sum  = sum ^ bus.in_data;
`endif
          if (beat == LAST_BEAT) begin
            nxt_state     = WRITE;
            nxt_beat      = '0;
            nxt_inst_addr = addr;
            nxt_inst_data = INST_WIDTH'({word, bus.in_data});
          end else begin
            nxt_beat = beat + BEAT_W'(1);
          end
        end
      end
      WRITE: begin
        if (addr == LAST_ADDR) begin
`ifdef CHECKSUM_EN
          nxt_state = CHECK;
`else
          nxt_state = DONE;
`endif
        end else begin
          nxt_addr  = addr + ADDR_WIDTH'(1);
          nxt_state = LOAD;
        end
      end
`ifdef CHECKSUM_EN
      CHECK: begin
        if (xfer) nxt_state = (bus.in_data == sum) ? DONE : ERROR;
      end
      ERROR: begin
        if (bus.start) begin
          nxt_state = LOAD;
          restart   = 1'b1;
        end
      end
`endif
      DONE: begin
        if (bus.start) begin
          nxt_state = LOAD;
          restart   = 1'b1;
        end
      end
      default: nxt_state = IDLE;
    endcase

    if (restart) begin
      nxt_addr = '0;
      nxt_beat = '0;
`ifdef CHECKSUM_EN
      nxt_sum  = '0;
`endif
    end

    // Outputs are registered versions of what the next state implies
`ifdef CHECKSUM_EN
    nxt_in_ready  = (nxt_state == LOAD) || (nxt_state == CHECK);
    nxt_error     = (nxt_state == ERROR);
`else
    nxt_in_ready  = (nxt_state == LOAD);
`endif
    nxt_write     = (nxt_state == WRITE);
    nxt_cpu_reset = (nxt_state != DONE);
    nxt_done      = (nxt_state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      addr        <= '0;
      beat        <= '0;
      word        <= '0;
      in_ready_q  <= 1'b0;
      write_q     <= 1'b0;
      inst_addr_q <= '0;
      inst_data_q <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
`ifdef CHECKSUM_EN
      sum         <= '0;
      error_q     <= 1'b0;
`endif
    end else begin
      state       <= nxt_state;
      addr        <= nxt_addr;
      beat        <= nxt_beat;
      word        <= nxt_word;
      in_ready_q  <= nxt_in_ready;
      write_q     <= nxt_write;
      inst_addr_q <= nxt_inst_addr;
      inst_data_q <= nxt_inst_data;
      cpu_reset_q <= nxt_cpu_reset;
      done_q      <= nxt_done;
`ifdef CHECKSUM_EN
      sum         <= nxt_sum;
      error_q     <= nxt_error;
`endif
    end
  end

  assign bus.in_ready       = in_ready_q;
  assign bus.ram_inst_write = write_q;
  assign bus.inst_addr      = inst_addr_q;
  assign bus.ram_inst_in    = inst_data_q;
  assign bus.cpu_reset      = cpu_reset_q;
  assign bus.load_done      = done_q;
`ifdef CHECKSUM_EN
  assign bus.load_error     = error_q;
`else
  assign bus.load_error     = 1'b0;
`endif
endmodule

// File: tb/tb_program_loader.sv
// Directed + randomized bench for program_loader (16-bit words, 4-word image); expected RAM
// writes come from the byte image itself, write timing from a per-byte transfer count.
`timescale 1ns/1ps
module tb_program_loader;
  localparam int IW    = 16;
  localparam int AW    = 2;
  localparam int NW    = 4;
  localparam int BEATS = IW / 8;
  localparam int NB    = NW * BEATS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  program_loader_if #(.INST_WIDTH(IW), .ADDR_WIDTH(AW)) bus ();
  program_loader #(.INST_WIDTH(IW), .ADDR_WIDTH(AW), .NUM_WORDS(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [IW-1:0] data;
  } wr_t;

  wr_t        wr_q[$];
  int         total = 0;
  int         bad = 0;
  int         epoch = 0;
  int         seen_epoch = 0;
  int         acc = 0;
  logic       exp_wr = 1'b0;
  logic [7:0] img [NB];
`ifdef CHECKSUM_EN
  logic       bad_trailer = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Records every RAM write; a write is due exactly one cycle after each BEATS-th accepted image byte
  always @(negedge clk) begin
    if (epoch != seen_epoch) begin
      seen_epoch = epoch;
      acc = 0;
      wr_q.delete();
    end
    if (rst) begin
      exp_wr = 1'b0;
    end else begin
      chk("write_timing", bus.ram_inst_write, exp_wr);
      if (bus.ram_inst_write) begin
        chk("ready_low_in_write", bus.in_ready, 0);
        wr_q.push_back('{addr: bus.inst_addr, data: bus.ram_inst_in});
      end
      exp_wr = 1'b0;
      if (bus.in_valid && bus.in_ready) begin
        acc++;
        if (acc <= NB && (acc % BEATS) == 0) exp_wr = 1'b1;
      end
    end
  end

  function automatic logic [7:0] img_xor();
    logic [7:0] x = 8'h00;
    for (int i = 0; i < NB; i++) x ^= img[i];
    return x;
  endfunction

  function automatic int gap_for(input int mode);
    if (mode == 0) return 0;
    if (mode == 1) return 1;
    return int'($urandom_range(0, 2));
  endfunction

  task automatic push(input logic [7:0] b, input int gap);
    logic rdy;
    int   n;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 50);
    chk("byte_accepted", rdy, 1);
    bus.in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic begin_load();
    epoch++;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("cpu_reset_in_load", bus.cpu_reset, 1);
    chk("done_low_in_load", bus.load_done, 0);
    chk("ready_in_load", bus.in_ready, 1);
`ifdef CHECKSUM_EN
    chk("error_cleared", bus.load_error, 0);
`endif
  endtask

  task automatic send_trailer();
`ifdef CHECKSUM_EN
    push(bad_trailer ? (img_xor() ^ 8'h01) : img_xor(), 0);
`endif
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(bus.load_done || bus.load_error) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("load_finished", bus.load_done || bus.load_error, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_image(input int mode);
    begin_load();
    for (int i = 0; i < NB; i++) push(img[i], gap_for(mode));
    send_trailer();
    wait_end();
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_write_count"}, wr_q.size(), NW);
    for (int i = 0; i < NW && i < wr_q.size(); i++) begin
      chk({tag, "_addr"}, wr_q[i].addr, i);
      chk({tag, "_data"}, wr_q[i].data, img[2*i] * 256 + img[2*i+1]);
    end
  endtask

  task automatic check_done(input string tag);
    check_writes(tag);
    chk({tag, "_cpu_reset"}, bus.cpu_reset, 0);
    chk({tag, "_load_done"}, bus.load_done, 1);
    chk({tag, "_load_error"}, bus.load_error, 0);
    chk({tag, "_ready_idle"}, bus.in_ready, 0);
    chk({tag, "_addr_hold"}, bus.inst_addr, NW - 1);
    chk({tag, "_data_hold"}, bus.ram_inst_in, img[NB-2] * 256 + img[NB-1]);
  endtask

  task automatic set_fixed_image();
    for (int i = 0; i < NB; i++) img[i] = 8'((i * 2 + 1) * 8'h12 + i * 8'h10);
    img[0] = 8'h12; img[1] = 8'h34; img[2] = 8'h56; img[3] = 8'h78;
    img[4] = 8'h9A; img[5] = 8'hBC; img[6] = 8'hDE; img[7] = 8'hF0;
  endtask

  task automatic set_random_image();
    for (int i = 0; i < NB; i++) img[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_cpu_reset"}, bus.cpu_reset, 1);
    chk({tag, "_in_ready"}, bus.in_ready, 0);
    chk({tag, "_write"}, bus.ram_inst_write, 0);
    chk({tag, "_inst_addr"}, bus.inst_addr, 0);
    chk({tag, "_inst_data"}, bus.ram_inst_in, 0);
    chk({tag, "_load_done"}, bus.load_done, 0);
    chk({tag, "_load_error"}, bus.load_error, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_ready_low", bus.in_ready, 0);
    chk("idle_cpu_reset", bus.cpu_reset, 1);

    // Back-to-back stream
    set_fixed_image();
    run_image(0);
    check_done("full_rate");

    // Bytes offered after the image are refused
    bus.in_data = 8'hAA;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("ready_after_done", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    chk("no_extra_writes", wr_q.size(), NW);
    @(posedge clk);
    #1;

    // in_valid toggling
    run_image(1);
    check_done("toggle_valid");

    // Start while loading is ignored
    begin_load();
    for (int i = 0; i < 3; i++) push(img[i], 0);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int i = 3; i < NB; i++) push(img[i], 0);
    send_trailer();
    wait_end();
    check_done("start_ignored");

    // Reset mid-load, then a clean reload
    set_random_image();
    begin_load();
    for (int i = 0; i < 5; i++) push(img[i], 0);
    rst = 1'b1;
    epoch++;
    #1;
    check_reset_values("midload_reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("after_reset_idle", bus.in_ready, 0);
    set_random_image();
    run_image(0);
    check_done("reload_after_reset");

`ifdef CHECKSUM_EN
    // Bad trailer reaches ERROR and stays there until Start
    set_fixed_image();
    bad_trailer = 1'b1;
    run_image(0);
    check_writes("bad_sum");
    repeat (3) @(posedge clk);
    #1;
    chk("bad_sum_error", bus.load_error, 1);
    chk("bad_sum_cpu_reset", bus.cpu_reset, 1);
    chk("bad_sum_done", bus.load_done, 0);
    chk("bad_sum_ready", bus.in_ready, 0);
    bad_trailer = 1'b0;
    set_random_image();
    run_image(2);
    check_done("good_after_error");
`endif

    // Random images with random gaps
    for (int r = 0; r < 6; r++) begin
      set_random_image();
      run_image(2);
      check_done("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
